// File: rtl/ddr_read_capture.sv
// DDR read-capture datapath: delays each read command by its CAS latency, then
// assembles one {rise,fall} word per cycle for a full burst toward the system port.
module ddr_read_capture #(
  parameter int unsigned DQ_WIDTH  = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_CL    = 7,
  parameter int unsigned CL_W      = 3,
  localparam int unsigned WORD_W   = 2 * DQ_WIDTH,
  localparam int unsigned NBEATS   = BURST_LEN / 2,
  localparam int unsigned BI_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  input  logic                rd_cmd,
  input  logic [CL_W-1:0]     cas_lat,
  input  logic [DQ_WIDTH-1:0] ddr_dq_rise,
  input  logic [DQ_WIDTH-1:0] ddr_dq_fall,
  output logic [WORD_W-1:0]   sys_data_r,
  output logic                data_out_rdy,
  output logic                data_last,
  output logic [BI_W-1:0]     beat_idx,
  output logic                busy,
  output logic                rd_err
);

  localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(NBEATS - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t              state, state_n;
  logic [BI_W-1:0]     cnt, cnt_n;
  logic [MAX_CL-1:0]   line, line_n;
  logic [WORD_W-1:0]   data_n;
  logic                rdy_n, last_n, busy_n, err_n;
  logic [BI_W-1:0]     beat_n;
  logic [CL_W-1:0]     cl;
  logic                start;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      line         <= '0;
      sys_data_r   <= '0;
      data_out_rdy <= 1'b0;
      data_last    <= 1'b0;
      beat_idx     <= '0;
      busy         <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      line         <= line_n;
      sys_data_r   <= data_n;
      data_out_rdy <= rdy_n;
      data_last    <= last_n;
      beat_idx     <= beat_n;
      busy         <= busy_n;
      rd_err       <= err_n;
    end
  end

  // Latency line, capture FSM and collision tracking
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = sys_data_r;
    rdy_n   = 1'b0;
    last_n  = 1'b0;
    beat_n  = beat_idx;
    err_n   = rd_err;
    line_n  = line >> 1;
    start   = line[0];

    if (cas_lat == '0)                  cl = CL_W'(1);
    else if (cas_lat > CL_W'(MAX_CL))   cl = CL_W'(MAX_CL);
    else                                cl = cas_lat;

    // Tap CL-1 of the shifted line emerges exactly CL cycles from now
    if (rd_cmd && init_done) begin
      for (int i = 0; i < int'(MAX_CL); i++) begin
        if (cl == CL_W'(i + 1)) begin
          if (line_n[i]) err_n     = 1'b1;
          else           line_n[i] = 1'b1;
        end
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n = (NBEATS > 1) ? CAPTURE : IDLE;
          cnt_n   = BI_W'(1);
          data_n  = {ddr_dq_rise, ddr_dq_fall};
          rdy_n   = 1'b1;
          beat_n  = '0;
          last_n  = (NBEATS == 1);
        end
      end
      CAPTURE: begin
        if (start) err_n = 1'b1;
        data_n = {ddr_dq_rise, ddr_dq_fall};
        rdy_n  = 1'b1;
        beat_n = cnt;
        last_n = (cnt == LAST_BEAT);
        if (cnt == LAST_BEAT) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + BI_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (|line_n) | (state_n == CAPTURE);
  end

endmodule

// File: tb/tb_ddr_read_capture.sv
// Bench for ddr_read_capture: directed vector table, a wide-burst sequence, and
// randomized traffic checked against an event-time reference model.
module tb_ddr_read_capture;

  logic        clk = 1'b0;
  logic        rst, init_done;
  logic        rd0, rd1;
  logic [2:0]  cl0, cl1;
  logic [7:0]  rise0, fall0;
  logic [15:0] rise1, fall1;
  logic [15:0] data0;
  logic [31:0] data1;
  logic        rdy0, last0, busy0, err0;
  logic        rdy1, last1, busy1, err1;
  logic [0:0]  beat0;
  logic [1:0]  beat1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ddr_read_capture #(.DQ_WIDTH(8), .BURST_LEN(4), .MAX_CL(7), .CL_W(3)) dut0 (
    .clk(clk), .rst(rst), .init_done(init_done), .rd_cmd(rd0), .cas_lat(cl0),
    .ddr_dq_rise(rise0), .ddr_dq_fall(fall0), .sys_data_r(data0),
    .data_out_rdy(rdy0), .data_last(last0), .beat_idx(beat0), .busy(busy0), .rd_err(err0));

  ddr_read_capture #(.DQ_WIDTH(16), .BURST_LEN(8), .MAX_CL(5), .CL_W(3)) dut1 (
    .clk(clk), .rst(rst), .init_done(init_done), .rd_cmd(rd1), .cas_lat(cl1),
    .ddr_dq_rise(rise1), .ddr_dq_fall(fall1), .sys_data_r(data1),
    .data_out_rdy(rdy1), .data_last(last1), .beat_idx(beat1), .busy(busy1), .rd_err(err1));

  // Reference model: pending emergence times per cycle, burst start time, sticky error
  bit          pend_at [2][8192];
  int          ts [2];
  bit          m_err [2];
  bit          e_rdy [2], e_last [2], e_busy [2];
  int          e_beat [2];
  logic [31:0] e_data [2];

  function automatic int nb(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int maxcl(input int d);
    return (d == 0) ? 7 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 8192; i++) pend_at[d][i] = 1'b0;
    ts[d] = -100; m_err[d] = 1'b0;
    e_rdy[d] = 1'b0; e_last[d] = 1'b0; e_busy[d] = 1'b0; e_beat[d] = 0; e_data[d] = '0;
  endtask

  // Advance the model across cycle cyc given that cycle's inputs
  task automatic model_upd(input int d, input bit rd, input int cl_in, input logic [31:0] word);
    int cl;
    bit any;
    if (rst) begin
      for (int i = cyc; i < cyc + 16; i++) pend_at[d][i] = 1'b0;
      ts[d] = -100; m_err[d] = 1'b0;
      e_rdy[d] = 1'b0; e_last[d] = 1'b0; e_busy[d] = 1'b0; e_beat[d] = 0; e_data[d] = '0;
      return;
    end
    if (pend_at[d][cyc]) begin
      pend_at[d][cyc] = 1'b0;
      if (cyc >= ts[d] && cyc <= ts[d] + nb(d) - 1) m_err[d] = 1'b1;
      else ts[d] = cyc;
    end
    if (cyc >= ts[d] && cyc <= ts[d] + nb(d) - 1) begin
      e_rdy[d]  = 1'b1;
      e_beat[d] = cyc - ts[d];
      e_last[d] = (cyc - ts[d] == nb(d) - 1);
      e_data[d] = word;
    end else begin
      e_rdy[d]  = 1'b0;
      e_last[d] = 1'b0;
    end
    if (rd && init_done) begin
      cl = (cl_in == 0) ? 1 : (cl_in > maxcl(d)) ? maxcl(d) : cl_in;
      if (pend_at[d][cyc + cl]) m_err[d] = 1'b1;
      else pend_at[d][cyc + cl] = 1'b1;
    end
    any = 1'b0;
    for (int i = cyc + 1; i <= cyc + maxcl(d); i++) any |= pend_at[d][i];
    e_busy[d] = any || (cyc + 1 > ts[d] && cyc + 1 <= ts[d] + nb(d) - 1);
  endtask

  task automatic check_model(input int d);
    string p;
    p = (d == 0) ? "m0" : "m1";
    if (d == 0) begin
      chk({p, "_rdy"},  32'(rdy0),  32'(e_rdy[0]));
      chk({p, "_err"},  32'(err0),  32'(m_err[0]));
      chk({p, "_busy"}, 32'(busy0), 32'(e_busy[0]));
      chk({p, "_data"}, 32'(data0), e_data[0]);
      if (e_rdy[0]) begin
        chk({p, "_last"}, 32'(last0), 32'(e_last[0]));
        chk({p, "_beat"}, 32'(beat0), 32'(e_beat[0]));
      end
    end else begin
      chk({p, "_rdy"},  32'(rdy1),  32'(e_rdy[1]));
      chk({p, "_err"},  32'(err1),  32'(m_err[1]));
      chk({p, "_busy"}, 32'(busy1), 32'(e_busy[1]));
      chk({p, "_data"}, data1,      e_data[1]);
      if (e_rdy[1]) begin
        chk({p, "_last"}, 32'(last1), 32'(e_last[1]));
        chk({p, "_beat"}, 32'(beat1), 32'(e_beat[1]));
      end
    end
  endtask

  task automatic step();
    model_upd(0, rd0, int'(cl0), {16'h0, rise0, fall0});
    model_upd(1, rd1, int'(cl1), {rise1, fall1});
    @(posedge clk);
    #1;
    cyc++;
    check_model(0);
    check_model(1);
  endtask

  // Directed vectors for the narrow instance: inputs of a cycle, outputs seen after its edge
  typedef struct {
    bit          rst, init, rd;
    logic [2:0]  cl;
    logic [7:0]  rise, fall;
    bit          rdy, last;
    logic        beat;
    logic [15:0] data;
    bit          err;
  } vec_t;

  vec_t vt [35];

  function automatic vec_t mk(input bit r, input bit in, input bit rd, input logic [2:0] cl,
                              input logic [7:0] ri, input logic [7:0] fa, input bit rdy,
                              input bit last, input logic beat, input logic [15:0] data,
                              input bit err);
    vec_t v;
    v.rst = r; v.init = in; v.rd = rd; v.cl = cl; v.rise = ri; v.fall = fa;
    v.rdy = rdy; v.last = last; v.beat = beat; v.data = data; v.err = err;
    return v;
  endfunction

  logic [31:0] w1 [4];

  initial begin
    // reset mid-burst
    vt[0]  = mk(0,1,1,3'd1,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[1]  = mk(0,1,0,3'd0,8'hAA,8'hBB, 1,0,0,16'hAABB,0);
    vt[2]  = mk(1,1,0,3'd0,8'hCC,8'hDD, 0,0,0,16'h0000,0);
    vt[3]  = mk(1,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[4]  = mk(1,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[5]  = mk(0,1,0,3'd0,8'hEE,8'hEE, 0,0,0,16'h0000,0);
    vt[6]  = mk(0,1,0,3'd0,8'hEE,8'hEE, 0,0,0,16'h0000,0);
    // single read, CL 3
    vt[7]  = mk(0,1,1,3'd3,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[8]  = mk(0,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[9]  = mk(0,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h0000,0);
    vt[10] = mk(0,1,0,3'd0,8'hA1,8'hB2, 1,0,0,16'hA1B2,0);
    vt[11] = mk(0,1,0,3'd0,8'hC3,8'hD4, 1,1,1,16'hC3D4,0);
    vt[12] = mk(0,1,0,3'd0,8'h55,8'h55, 0,0,0,16'hC3D4,0);
    // cas_lat 0 clamps to 1
    vt[13] = mk(0,1,1,3'd0,8'h00,8'h00, 0,0,0,16'hC3D4,0);
    vt[14] = mk(0,1,0,3'd0,8'h12,8'h34, 1,0,0,16'h1234,0);
    vt[15] = mk(0,1,0,3'd0,8'h56,8'h78, 1,1,1,16'h5678,0);
    vt[16] = mk(0,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h5678,0);
    // back-to-back, CL 2
    vt[17] = mk(0,1,1,3'd2,8'h00,8'h00, 0,0,0,16'h5678,0);
    vt[18] = mk(0,1,0,3'd0,8'h00,8'h00, 0,0,0,16'h5678,0);
    vt[19] = mk(0,1,1,3'd2,8'h11,8'h22, 1,0,0,16'h1122,0);
    vt[20] = mk(0,1,0,3'd0,8'h33,8'h44, 1,1,1,16'h3344,0);
    vt[21] = mk(0,1,0,3'd0,8'h55,8'h66, 1,0,0,16'h5566,0);
    vt[22] = mk(0,1,0,3'd0,8'h77,8'h88, 1,1,1,16'h7788,0);
    vt[23] = mk(0,1,0,3'd0,8'h99,8'h99, 0,0,0,16'h7788,0);
    // read ignored while init_done low
    vt[24] = mk(0,0,1,3'd3,8'h00,8'h00, 0,0,0,16'h7788,0);
    vt[25] = mk(0,1,0,3'd0,8'h01,8'h02, 0,0,0,16'h7788,0);
    vt[26] = mk(0,1,0,3'd0,8'h03,8'h04, 0,0,0,16'h7788,0);
    vt[27] = mk(0,1,0,3'd0,8'h05,8'h06, 0,0,0,16'h7788,0);
    vt[28] = mk(0,1,0,3'd0,8'h07,8'h08, 0,0,0,16'h7788,0);
    // collision, CL 2 at T and T+1
    vt[29] = mk(0,1,1,3'd2,8'h00,8'h00, 0,0,0,16'h7788,0);
    vt[30] = mk(0,1,1,3'd2,8'h00,8'h00, 0,0,0,16'h7788,0);
    vt[31] = mk(0,1,0,3'd0,8'h9A,8'hBC, 1,0,0,16'h9ABC,0);
    vt[32] = mk(0,1,0,3'd0,8'hDE,8'hF0, 1,1,1,16'hDEF0,1);
    vt[33] = mk(0,1,0,3'd0,8'h12,8'h12, 0,0,0,16'hDEF0,1);
    vt[34] = mk(0,1,0,3'd0,8'h34,8'h34, 0,0,0,16'hDEF0,1);

    w1[0] = 32'h0123_4567; w1[1] = 32'h89AB_CDEF;
    w1[2] = 32'hDEAD_BEEF; w1[3] = 32'hFEED_F00D;

    model_reset(0);
    model_reset(1);
    rst = 1'b1; init_done = 1'b1;
    rd0 = 1'b0; cl0 = '0; rise0 = '0; fall0 = '0;
    rd1 = 1'b0; cl1 = '0; rise1 = '0; fall1 = '0;
    step();
    chk("rst_rdy0", 32'(rdy0), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    step();
    rst = 1'b0;

    foreach (vt[i]) begin
      rst = vt[i].rst; init_done = vt[i].init;
      rd0 = vt[i].rd; cl0 = vt[i].cl; rise0 = vt[i].rise; fall0 = vt[i].fall;
      step();
      chk($sformatf("tbl%0d_rdy", i),  32'(rdy0),  32'(vt[i].rdy));
      chk($sformatf("tbl%0d_data", i), 32'(data0), 32'(vt[i].data));
      chk($sformatf("tbl%0d_err", i),  32'(err0),  32'(vt[i].err));
      if (vt[i].rdy) begin
        chk($sformatf("tbl%0d_last", i), 32'(last0), 32'(vt[i].last));
        chk($sformatf("tbl%0d_beat", i), 32'(beat0), 32'(vt[i].beat));
      end
    end
    rst = 1'b0; init_done = 1'b1; rd0 = 1'b0;

    // Wide instance: cas_lat 7 clamps to MAX_CL 5, four 32-bit words
    rd1 = 1'b1; cl1 = 3'd7;
    step();
    chk("wide_rdy_t1", 32'(rdy1), 32'd0);
    rd1 = 1'b0; cl1 = '0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("wide_early%0d", i), 32'(rdy1), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      {rise1, fall1} = w1[k];
      step();
      chk($sformatf("wide_rdy%0d", k),  32'(rdy1),  32'd1);
      chk($sformatf("wide_beat%0d", k), 32'(beat1), 32'(k));
      chk($sformatf("wide_last%0d", k), 32'(last1), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("wide_data%0d", k), data1,      w1[k]);
    end
    {rise1, fall1} = 32'h1111_2222;
    step();
    chk("wide_end_rdy", 32'(rdy1), 32'd0);
    chk("wide_hold",    data1,     w1[3]);
    chk("wide_err",     32'(err1), 32'd0);

    // Randomized traffic on both instances
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      init_done = ($urandom_range(0, 19) != 0);
      rd0   = ($urandom_range(0, 3) == 0);
      cl0   = 3'($urandom_range(0, 7));
      rise0 = 8'($urandom); fall0 = 8'($urandom);
      rd1   = ($urandom_range(0, 5) == 0);
      cl1   = 3'($urandom_range(0, 7));
      rise1 = 16'($urandom); fall1 = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
